// File: rtl/axi_slice_pkg.sv
// Shared definitions for the configurable AXI4 register slice.
// Provides per-channel payload width helpers, the buffer mode
// classification used by axi_chan_buf, and the maximum buffer depth.
package axi_slice_pkg;

  localparam int unsigned MAX_SLICE_DEPTH = 16;

  typedef enum logic [1:0] {
    BUF_BYPASS,
    BUF_HALF,
    BUF_FIFO
  } buf_mode_e;

  function automatic buf_mode_e buf_mode(input int unsigned depth);
    if (depth == 0) return BUF_BYPASS;
    if (depth == 1) return BUF_HALF;
    return BUF_FIFO;
  endfunction

  // addr + prot(3) region(4) len(8) size(3) burst(2) lock(1) cache(4) qos(4) + id + user
  function automatic int unsigned aw_payload_w(input int unsigned addr_w,
                                               input int unsigned id_w,
                                               input int unsigned user_w);
    return addr_w + 29 + id_w + user_w;
  endfunction

  // data + strb + user + last
  function automatic int unsigned w_payload_w(input int unsigned data_w,
                                              input int unsigned user_w);
    return data_w + data_w / 8 + user_w + 1;
  endfunction

  // resp(2) + id + user
  function automatic int unsigned b_payload_w(input int unsigned id_w,
                                              input int unsigned user_w);
    return 2 + id_w + user_w;
  endfunction

  // data + resp(2) + last + id + user
  function automatic int unsigned r_payload_w(input int unsigned data_w,
                                              input int unsigned id_w,
                                              input int unsigned user_w);
    return data_w + 3 + id_w + user_w;
  endfunction

endpackage

// File: rtl/AXI_BUS.sv
// AXI4 bus bundle with Master and Slave modports.
// Master drives AW/W/AR payload+valid and R/B ready; Slave the reverse.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [3:0]                aw_qos;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_last;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [3:0]                ar_qos;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_qos, aw_id, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_user, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_id, b_user, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_qos, ar_id, ar_user, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_id, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_qos, aw_id, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_user, w_last, w_valid,
    output w_ready,
    output b_resp, b_id, b_user, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_qos, ar_id, ar_user, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_id, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_chan_buf.sv
// Generic valid/ready channel buffer.
//   DEPTH 0 : combinational pass-through, always empty.
//   DEPTH 1 : single register, ready = !full (half throughput).
//   DEPTH N : circular FIFO, ready registered, full throughput.
// Ports: clk_i/rst_i (sync, active-high), in_* upstream handshake+data,
// out_* downstream handshake+data, empty_o high when nothing is buffered.
module axi_chan_buf
  import axi_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             empty_o
);

  localparam buf_mode_e MODE = buf_mode(DEPTH);

  if (DEPTH > MAX_SLICE_DEPTH) begin : g_depth_check
    $error("axi_chan_buf: DEPTH %0d exceeds %0d", DEPTH, MAX_SLICE_DEPTH);
  end

  if (MODE == BUF_BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign out_valid_o    = in_valid_i;
    assign in_ready_o     = out_ready_i;
    assign out_data_o     = in_data_i;
    assign empty_o        = 1'b1;
  end else if (MODE == BUF_HALF) begin : g_half
    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic             push;

    assign in_ready_o  = !full_q && !rst_i;
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;
    assign empty_o     = !full_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_q <= 1'b0;
      end else if (push) begin
        full_q <= 1'b1;
      end else if (full_q && out_ready_i) begin
        full_q <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) data_q <= in_data_i;
    end
  end else begin : g_fifo
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             not_full_q;
    logic             push;
    logic             pop;

    // Upstream ready comes from a flop updated with next-cycle occupancy,
    // so downstream ready never reaches upstream ready combinationally.
    assign in_ready_o  = not_full_q && !rst_i;
    assign out_valid_o = (count != '0);
    assign out_data_o  = mem[rd_ptr];
    assign empty_o     = (count == '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
      count_nxt = count;
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        not_full_q <= 1'b1;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        count      <= count_nxt;
        not_full_q <= (count_nxt != CNT_W'(DEPTH));
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= in_data_i;
    end
  end

endmodule

// File: rtl/axi_slice_cfg.sv
// Configurable AXI4 register slice. Each of AW, W, AR, R, B gets its own
// axi_chan_buf of depth 0 (wire), 1 (half register) or N (FIFO).
// Ports: clk_i, rst_i (sync, active-high), test_en_i (scan, no function),
// axi_slave (upstream), axi_master (downstream), idle_o (all buffers empty).
module axi_slice_cfg
  import axi_slice_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AW_DEPTH       = 2,
  parameter int unsigned W_DEPTH        = 2,
  parameter int unsigned AR_DEPTH       = 2,
  parameter int unsigned R_DEPTH        = 2,
  parameter int unsigned B_DEPTH        = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   test_en_i,
  AXI_BUS.Slave  axi_slave,
  AXI_BUS.Master axi_master,
  output logic   idle_o
);

  localparam int unsigned AW_W = aw_payload_w(AXI_ADDR_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH);
  localparam int unsigned W_W  = w_payload_w(AXI_DATA_WIDTH, AXI_USER_WIDTH);
  localparam int unsigned B_W  = b_payload_w(AXI_ID_WIDTH, AXI_USER_WIDTH);
  localparam int unsigned R_W  = r_payload_w(AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH);

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  logic [AW_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;
  logic            aw_empty, w_empty, ar_empty, r_empty, b_empty;

  assign aw_in = {axi_slave.aw_addr, axi_slave.aw_prot, axi_slave.aw_region,
                  axi_slave.aw_len, axi_slave.aw_size, axi_slave.aw_burst,
                  axi_slave.aw_lock, axi_slave.aw_cache, axi_slave.aw_qos,
                  axi_slave.aw_id, axi_slave.aw_user};
  assign {axi_master.aw_addr, axi_master.aw_prot, axi_master.aw_region,
          axi_master.aw_len, axi_master.aw_size, axi_master.aw_burst,
          axi_master.aw_lock, axi_master.aw_cache, axi_master.aw_qos,
          axi_master.aw_id, axi_master.aw_user} = aw_out;

  assign ar_in = {axi_slave.ar_addr, axi_slave.ar_prot, axi_slave.ar_region,
                  axi_slave.ar_len, axi_slave.ar_size, axi_slave.ar_burst,
                  axi_slave.ar_lock, axi_slave.ar_cache, axi_slave.ar_qos,
                  axi_slave.ar_id, axi_slave.ar_user};
  assign {axi_master.ar_addr, axi_master.ar_prot, axi_master.ar_region,
          axi_master.ar_len, axi_master.ar_size, axi_master.ar_burst,
          axi_master.ar_lock, axi_master.ar_cache, axi_master.ar_qos,
          axi_master.ar_id, axi_master.ar_user} = ar_out;

  assign w_in = {axi_slave.w_data, axi_slave.w_strb, axi_slave.w_user, axi_slave.w_last};
  assign {axi_master.w_data, axi_master.w_strb, axi_master.w_user, axi_master.w_last} = w_out;

  assign b_in = {axi_master.b_resp, axi_master.b_id, axi_master.b_user};
  assign {axi_slave.b_resp, axi_slave.b_id, axi_slave.b_user} = b_out;

  assign r_in = {axi_master.r_data, axi_master.r_resp, axi_master.r_last,
                 axi_master.r_id, axi_master.r_user};
  assign {axi_slave.r_data, axi_slave.r_resp, axi_slave.r_last,
          axi_slave.r_id, axi_slave.r_user} = r_out;

  axi_chan_buf #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_buf (
    .clk_i, .rst_i,
    .in_valid_i (axi_slave.aw_valid),  .in_ready_o (axi_slave.aw_ready),  .in_data_i (aw_in),
    .out_valid_o(axi_master.aw_valid), .out_ready_i(axi_master.aw_ready), .out_data_o(aw_out),
    .empty_o    (aw_empty)
  );

  axi_chan_buf #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_buf (
    .clk_i, .rst_i,
    .in_valid_i (axi_slave.w_valid),  .in_ready_o (axi_slave.w_ready),  .in_data_i (w_in),
    .out_valid_o(axi_master.w_valid), .out_ready_i(axi_master.w_ready), .out_data_o(w_out),
    .empty_o    (w_empty)
  );

  axi_chan_buf #(.WIDTH(AW_W), .DEPTH(AR_DEPTH)) u_ar_buf (
    .clk_i, .rst_i,
    .in_valid_i (axi_slave.ar_valid),  .in_ready_o (axi_slave.ar_ready),  .in_data_i (ar_in),
    .out_valid_o(axi_master.ar_valid), .out_ready_i(axi_master.ar_ready), .out_data_o(ar_out),
    .empty_o    (ar_empty)
  );

  axi_chan_buf #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r_buf (
    .clk_i, .rst_i,
    .in_valid_i (axi_master.r_valid), .in_ready_o (axi_master.r_ready), .in_data_i (r_in),
    .out_valid_o(axi_slave.r_valid),  .out_ready_i(axi_slave.r_ready),  .out_data_o(r_out),
    .empty_o    (r_empty)
  );

  axi_chan_buf #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_buf (
    .clk_i, .rst_i,
    .in_valid_i (axi_master.b_valid), .in_ready_o (axi_master.b_ready), .in_data_i (b_in),
    .out_valid_o(axi_slave.b_valid),  .out_ready_i(axi_slave.b_ready),  .out_data_o(b_out),
    .empty_o    (b_empty)
  );

  assign idle_o = aw_empty && w_empty && ar_empty && r_empty && b_empty;

endmodule

// File: tb/tb_axi_slice_cfg.sv
module tb_axi_slice_cfg;
  localparam int unsigned AW_D = 0, W_D = 2, AR_D = 4, R_D = 3, B_D = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic test_en = 1'b0;
  logic idle;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) slv ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) mst ();

  axi_slice_cfg #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(6),
    .AW_DEPTH(AW_D), .W_DEPTH(W_D), .AR_DEPTH(AR_D), .R_DEPTH(R_D), .B_DEPTH(B_D)
  ) dut (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
    .axi_slave(slv), .axi_master(mst), .idle_o(idle)
  );

  // A beat as seen by the reference model: main data, id, last flag and
  // a bundle of secondary fields.
  typedef struct {
    logic [63:0] d;
    logic [5:0]  id;
    logic        last;
    logic [63:0] aux;
  } beat_t;

  beat_t q[$];
  beat_t cur;
  int    checks = 0;
  int    errors = 0;
  int    sent, got, first_acc, first_out, last_out;
  logic  exp_rdy, push, pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.d    = {$urandom, $urandom};
    b.id   = 6'($urandom);
    b.last = 1'($urandom_range(0, 1));
    b.aux  = 64'($urandom_range(0, 1023));
    return b;
  endfunction

  initial begin
    slv.aw_valid = 0; slv.aw_addr = '0; slv.aw_prot = '0; slv.aw_region = '0; slv.aw_len = '0;
    slv.aw_size = '0; slv.aw_burst = '0; slv.aw_lock = 0; slv.aw_cache = '0; slv.aw_qos = '0;
    slv.aw_id = '0; slv.aw_user = '0;
    slv.w_valid = 0; slv.w_data = '0; slv.w_strb = '0; slv.w_user = '0; slv.w_last = 0;
    slv.ar_valid = 0; slv.ar_addr = '0; slv.ar_prot = '0; slv.ar_region = '0; slv.ar_len = '0;
    slv.ar_size = '0; slv.ar_burst = '0; slv.ar_lock = 0; slv.ar_cache = '0; slv.ar_qos = '0;
    slv.ar_id = '0; slv.ar_user = '0;
    slv.r_ready = 1; slv.b_ready = 1;
    mst.aw_ready = 1; mst.w_ready = 1; mst.ar_ready = 1;
    mst.r_valid = 0; mst.r_data = '0; mst.r_resp = '0; mst.r_last = 0; mst.r_id = '0; mst.r_user = '0;
    mst.b_valid = 0; mst.b_resp = '0; mst.b_id = '0; mst.b_user = '0;

    // Reset held for 3 cycles: buffered valids/readies low, AW is a wire.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_w_valid", 64'(mst.w_valid), 64'd0);
      chk("rst_ar_valid", 64'(mst.ar_valid), 64'd0);
      chk("rst_r_valid", 64'(slv.r_valid), 64'd0);
      chk("rst_b_valid", 64'(slv.b_valid), 64'd0);
      chk("rst_w_ready", 64'(slv.w_ready), 64'd0);
      chk("rst_ar_ready", 64'(slv.ar_ready), 64'd0);
      chk("rst_r_ready", 64'(mst.r_ready), 64'd0);
      chk("rst_b_ready", 64'(mst.b_ready), 64'd0);
      chk("rst_aw_ready_wire", 64'(slv.aw_ready), 64'd1);
    end
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_w_ready", 64'(slv.w_ready), 64'd1);
    chk("post_rst_ar_ready", 64'(slv.ar_ready), 64'd1);
    chk("post_rst_r_ready", 64'(mst.r_ready), 64'd1);
    chk("post_rst_b_ready", 64'(mst.b_ready), 64'd1);
    chk("post_rst_idle", 64'(idle), 64'd1);
    tick();

    // W throughput: 16 beats, data 0..15, downstream always ready.
    q.delete(); sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      slv.w_valid = (sent < 16);
      slv.w_data  = 64'(sent);
      slv.w_last  = (sent == 15);
      slv.w_strb  = 8'($urandom);
      slv.w_user  = 6'($urandom);
      @(negedge clk);
      exp_rdy = (q.size() != W_D);
      chk("w_ready", 64'(slv.w_ready), 64'(exp_rdy));
      chk("w_valid", 64'(mst.w_valid), 64'(q.size() != 0));
      chk("w_idle", 64'(idle), 64'(q.size() == 0));
      pop = (q.size() != 0);
      if (pop) begin
        chk("w_data", mst.w_data, q[0].d);
        chk("w_last", 64'(mst.w_last), 64'(q[0].last));
        chk("w_strb_user", 64'({mst.w_strb, mst.w_user}), q[0].aux);
        if (first_out < 0) first_out = c;
        last_out = c;
        got++;
      end
      push = slv.w_valid && exp_rdy;
      if (push) begin
        cur.d = 64'(sent); cur.id = '0; cur.last = (sent == 15);
        cur.aux = 64'({slv.w_strb, slv.w_user});
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(cur);
      tick();
    end
    slv.w_valid = 0;
    chk("w_count", 64'(got), 64'd16);
    chk("w_latency", 64'(first_out - first_acc), 64'd1);
    chk("w_rate", 64'(last_out - first_out), 64'd15);

    // AR backpressure: downstream blocked for 10 cycles, 6 requests offered.
    q.delete(); sent = 0; got = 0;
    mst.ar_ready = 0;
    cur = rand_beat();
    for (int c = 0; c < 80 && got < 6; c++) begin
      if (c == 10) mst.ar_ready = 1;
      slv.ar_valid = (sent < 6);
      slv.ar_addr  = cur.d[31:0];
      slv.ar_id    = cur.id;
      slv.ar_len   = cur.aux[7:0];
      @(negedge clk);
      exp_rdy = (q.size() != AR_D);
      chk("ar_ready", 64'(slv.ar_ready), 64'(exp_rdy));
      chk("ar_valid", 64'(mst.ar_valid), 64'(q.size() != 0));
      chk("ar_idle", 64'(idle), 64'(q.size() == 0));
      pop = (q.size() != 0) && mst.ar_ready;
      if (q.size() != 0) begin
        chk("ar_addr", 64'(mst.ar_addr), 64'(q[0].d[31:0]));
        chk("ar_id", 64'(mst.ar_id), 64'(q[0].id));
        chk("ar_len", 64'(mst.ar_len), 64'(q[0].aux[7:0]));
      end
      push = slv.ar_valid && exp_rdy;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) begin
        cur.d = {32'd0, cur.d[31:0]}; cur.aux = {56'd0, cur.aux[7:0]};
        q.push_back(cur);
        sent++;
        cur = rand_beat();
      end
      if (c == 9) chk("ar_accepted_blocked", 64'(sent), 64'd4);
      tick();
    end
    slv.ar_valid = 0;
    chk("ar_count", 64'(got), 64'd6);
    @(negedge clk);
    chk("ar_idle_after", 64'(idle), 64'd1);
    chk("ar_valid_after", 64'(mst.ar_valid), 64'd0);
    tick();

    // B half register: continuous responses with id 0..7 over 16 cycles.
    q.delete(); sent = 0; got = 0;
    slv.b_ready = 1;
    for (int c = 0; c < 16; c++) begin
      mst.b_valid = (sent < 8);
      mst.b_id    = 6'(sent);
      mst.b_resp  = 2'(sent) ^ 2'b10;
      mst.b_user  = 6'(sent * 5);
      @(negedge clk);
      exp_rdy = (q.size() != B_D);
      chk("b_ready", 64'(mst.b_ready), 64'(exp_rdy));
      chk("b_ready_toggle", 64'(mst.b_ready), 64'(c % 2 == 0));
      chk("b_valid", 64'(slv.b_valid), 64'(q.size() != 0));
      pop = (q.size() != 0);
      if (pop) begin
        chk("b_id", 64'(slv.b_id), 64'(q[0].id));
        chk("b_resp_user", 64'({slv.b_resp, slv.b_user}), q[0].aux);
        got++;
      end
      push = mst.b_valid && exp_rdy;
      if (push) begin
        cur.d = '0; cur.last = 0; cur.id = mst.b_id;
        cur.aux = 64'({mst.b_resp, mst.b_user});
        sent++;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(cur);
      tick();
    end
    mst.b_valid = 0;
    chk("b_count_16cyc", 64'(got), 64'd8);

    // AW depth 0: valid, ready and payload are same-cycle wires.
    for (int c = 0; c < 8; c++) begin
      slv.aw_valid = 1'($urandom_range(0, 1));
      mst.aw_ready = 1'($urandom_range(0, 1));
      slv.aw_addr  = $urandom;
      slv.aw_id    = 6'($urandom);
      slv.aw_len   = 8'($urandom);
      slv.aw_qos   = 4'($urandom);
      @(negedge clk);
      chk("aw_valid_wire", 64'(mst.aw_valid), 64'(slv.aw_valid));
      chk("aw_ready_wire", 64'(slv.aw_ready), 64'(mst.aw_ready));
      chk("aw_addr_wire", 64'(mst.aw_addr), 64'(slv.aw_addr));
      chk("aw_id_len_qos", 64'({mst.aw_id, mst.aw_len, mst.aw_qos}),
          64'({slv.aw_id, slv.aw_len, slv.aw_qos}));
      chk("aw_idle", 64'(idle), 64'd1);
      tick();
    end
    slv.aw_valid = 0;

    // R depth 3: 10 beats with random downstream ready, wraps the pointers.
    q.delete(); sent = 0; got = 0;
    cur = rand_beat();
    for (int c = 0; c < 300 && got < 10; c++) begin
      mst.r_valid = (sent < 10);
      mst.r_data  = cur.d;
      mst.r_id    = cur.id;
      mst.r_last  = cur.last;
      mst.r_resp  = cur.aux[7:6];
      mst.r_user  = cur.aux[5:0];
      slv.r_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = (q.size() != R_D);
      chk("r_ready", 64'(mst.r_ready), 64'(exp_rdy));
      chk("r_valid", 64'(slv.r_valid), 64'(q.size() != 0));
      pop = (q.size() != 0) && slv.r_ready;
      if (q.size() != 0) begin
        chk("r_data", slv.r_data, q[0].d);
        chk("r_id", 64'(slv.r_id), 64'(q[0].id));
        chk("r_last", 64'(slv.r_last), 64'(q[0].last));
        chk("r_resp_user", 64'({slv.r_resp, slv.r_user}), 64'(q[0].aux[7:0]));
      end
      push = mst.r_valid && exp_rdy;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) begin
        q.push_back(cur);
        sent++;
        cur = rand_beat();
      end
      tick();
    end
    mst.r_valid = 0;
    chk("r_count", 64'(got), 64'd10);

    // Reset with 3 R beats buffered: everything discarded, nothing drains.
    slv.r_ready = 0;
    for (int c = 0; c < 3; c++) begin
      cur = rand_beat();
      mst.r_valid = 1; mst.r_data = cur.d; mst.r_id = cur.id;
      @(negedge clk);
      chk("rr_fill_ready", 64'(mst.r_ready), 64'd1);
      tick();
    end
    mst.r_valid = 0;
    @(negedge clk);
    chk("rr_full_valid", 64'(slv.r_valid), 64'd1);
    chk("rr_full_ready", 64'(mst.r_ready), 64'd0);
    chk("rr_full_idle", 64'(idle), 64'd0);
    tick();
    rst = 1;
    @(negedge clk);
    chk("rr_rst_ready", 64'(mst.r_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("rr_rst_valid", 64'(slv.r_valid), 64'd0);
    chk("rr_rst_idle", 64'(idle), 64'd1);
    tick();
    rst = 0;
    slv.r_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr_no_stale", 64'(slv.r_valid), 64'd0);
      chk("rr_idle", 64'(idle), 64'd1);
      chk("rr_ready", 64'(mst.r_ready), 64'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
